// File: rtl/calc_accumulator.sv
// calc_accumulator
//   Switch/button calculator core. A WIDTH-bit operand comes from the switches
//   and is combined into one of NUM_REGS accumulator registers. Raw buttons are
//   synchronised and debounced, then turned into single-cycle strobes that
//   drive store/add/subtract/select/view operations.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   btn_store   raw button: reg[sel] <= sw
//   btn_add     raw button: reg[sel] <= reg[sel] + sw (carry out recorded)
//   btn_sub     raw button: reg[sel] <= reg[sel] - sw (borrow recorded)
//   btn_sel     raw button: advance register select (wraps)
//   btn_view    raw button: toggle display source
//   sw          operand switches, asynchronous to clk
//   disp_value  registered value for the seven-segment path
//   reg_sel     currently selected register index
//   carry       carry/borrow flag of the selected register
//   view_reg    0 = display shows sw, 1 = display shows reg[sel]
module calc_accumulator #(
  parameter int WIDTH           = 16,
  parameter int NUM_REGS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        btn_store,
  input  logic                        btn_add,
  input  logic                        btn_sub,
  input  logic                        btn_sel,
  input  logic                        btn_view,
  input  logic [WIDTH-1:0]            sw,
  output logic [WIDTH-1:0]            disp_value,
  output logic [$clog2(NUM_REGS)-1:0] reg_sel,
  output logic                        carry,
  output logic                        view_reg
);

  // Button lane order inside the packed vectors below.
  localparam int B_STORE = 0;
  localparam int B_ADD   = 1;
  localparam int B_SUB   = 2;
  localparam int B_SEL   = 3;
  localparam int B_VIEW  = 4;
  localparam int NB      = 5;

  // The counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NB-1:0]    btn_raw;
  logic [NB-1:0]    btn_meta;
  logic [NB-1:0]    btn_sync;
  logic [NB-1:0]    btn_deb;
  logic [NB-1:0]    flip;
  logic [NB-1:0]    rise;
  logic [NB-1:0]    pulse;
  logic [CNT_W-1:0] cnt [NB];

  logic [WIDTH-1:0] sw_meta;
  logic [WIDTH-1:0] sw_s;

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] carry_flags;
  logic [WIDTH-1:0]    cur;
  logic [WIDTH:0]      sum;
  logic [WIDTH:0]      diff;

  assign btn_raw = {btn_view, btn_sel, btn_sub, btn_add, btn_store};

  // Two-flop synchronisers for the buttons and the switch operand. The
  // operand is not debounced; it is only sampled when a strobe fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= '0;
      btn_sync <= '0;
      sw_meta  <= '0;
      sw_s     <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
      sw_meta  <= sw;
      sw_s     <= sw_meta;
    end
  end

  // A level is accepted on the edge where it has already differed for
  // DEBOUNCE_CYCLES-1 counted cycles and still differs. Only press edges
  // (0->1) produce a strobe.
  always_comb begin
    flip = '0;
    for (int i = 0; i < NB; i++) begin
      flip[i] = (btn_sync[i] != btn_deb[i]) && (cnt[i] == CNT_MAX);
    end
    rise = flip & ~btn_deb;
  end

  // Per-button debounce counters and debounced levels. The strobe is
  // registered so it lands on the cycle after the debounced level flips.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        cnt[i] <= '0;
      end
      btn_deb <= '0;
      pulse   <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (btn_sync[i] == btn_deb[i]) begin
          cnt[i] <= '0;
        end else if (flip[i]) begin
          cnt[i]     <= '0;
          btn_deb[i] <= ~btn_deb[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      pulse <= rise;
    end
  end

  // Extended-width arithmetic: bit WIDTH of the sum is the carry, and bit
  // WIDTH of the difference is set exactly when sw_s > cur (borrow).
  always_comb begin
    cur  = regs[reg_sel];
    sum  = {1'b0, cur} + {1'b0, sw_s};
    diff = {1'b0, cur} - {1'b0, sw_s};
  end

  // Accumulator registers. Coincident strobes resolve as
  // store > add > sub > sel; view toggling is independent of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
      carry_flags <= '0;
      reg_sel     <= '0;
      view_reg    <= 1'b0;
      disp_value  <= '0;
    end else begin
      if (pulse[B_STORE]) begin
        regs[reg_sel]        <= sw_s;
        carry_flags[reg_sel] <= 1'b0;
      end else if (pulse[B_ADD]) begin
        regs[reg_sel]        <= sum[WIDTH-1:0];
        carry_flags[reg_sel] <= sum[WIDTH];
      end else if (pulse[B_SUB]) begin
        regs[reg_sel]        <= diff[WIDTH-1:0];
        carry_flags[reg_sel] <= diff[WIDTH];
      end else if (pulse[B_SEL]) begin
        reg_sel <= reg_sel + 1'b1;
      end
      if (pulse[B_VIEW]) begin
        view_reg <= ~view_reg;
      end
      disp_value <= view_reg ? cur : sw_s;
    end
  end

  assign carry = carry_flags[reg_sel];

endmodule

// File: tb/tb_calc_accumulator.sv
// tb_calc_accumulator
//   Self-checking bench for calc_accumulator with a short debounce window.
//   A plain arithmetic model of the register file tracks every accepted
//   button press and is compared against the DUT outputs once the press
//   has settled.
module tb_calc_accumulator;

  localparam int WIDTH    = 16;
  localparam int NUM_REGS = 4;
  localparam int DEB      = 4;

  // Button mask bits used by the stimulus tasks.
  localparam int M_STORE = 1;
  localparam int M_ADD   = 2;
  localparam int M_SUB   = 4;
  localparam int M_SEL   = 8;
  localparam int M_VIEW  = 16;

  logic             clk;
  logic             rst;
  logic             btn_store;
  logic             btn_add;
  logic             btn_sub;
  logic             btn_sel;
  logic             btn_view;
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] disp_value;
  logic [1:0]       reg_sel;
  logic             carry;
  logic             view_reg;

  calc_accumulator #(
    .WIDTH(WIDTH),
    .NUM_REGS(NUM_REGS),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_store(btn_store),
    .btn_add(btn_add),
    .btn_sub(btn_sub),
    .btn_sel(btn_sel),
    .btn_view(btn_view),
    .sw(sw),
    .disp_value(disp_value),
    .reg_sel(reg_sel),
    .carry(carry),
    .view_reg(view_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model state.
  int unsigned m_regs [NUM_REGS];
  bit          m_carry [NUM_REGS];
  int unsigned m_sel;
  bit          m_view;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int r = 0; r < NUM_REGS; r++) begin
      m_regs[r]  = 0;
      m_carry[r] = 1'b0;
    end
    m_sel  = 0;
    m_view = 1'b0;
  endtask

  // Apply one accepted press set to the model using plain arithmetic.
  task automatic modelOp(input int mask, input int unsigned value);
    int unsigned total;
    if ((mask & M_STORE) != 0) begin
      m_regs[m_sel]  = value;
      m_carry[m_sel] = 1'b0;
    end else if ((mask & M_ADD) != 0) begin
      total          = m_regs[m_sel] + value;
      m_carry[m_sel] = (total > 65535);
      m_regs[m_sel]  = total % 65536;
    end else if ((mask & M_SUB) != 0) begin
      m_carry[m_sel] = (value > m_regs[m_sel]);
      m_regs[m_sel]  = (m_regs[m_sel] + 65536 - value) % 65536;
    end else if ((mask & M_SEL) != 0) begin
      m_sel = (m_sel + 1) % NUM_REGS;
    end
    if ((mask & M_VIEW) != 0) begin
      m_view = ~m_view;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".disp"}, 32'(disp_value),
                m_view ? m_regs[m_sel] : 32'(sw));
    checkOutput({tag, ".sel"}, 32'(reg_sel), m_sel);
    checkOutput({tag, ".carry"}, 32'(carry), 32'(m_carry[m_sel]));
    checkOutput({tag, ".view"}, 32'(view_reg), 32'(m_view));
  endtask

  task automatic driveButtons(input int mask);
    btn_store = ((mask & M_STORE) != 0);
    btn_add   = ((mask & M_ADD) != 0);
    btn_sub   = ((mask & M_SUB) != 0);
    btn_sel   = ((mask & M_SEL) != 0);
    btn_view  = ((mask & M_VIEW) != 0);
  endtask

  // Set the operand, let it settle, hold the buttons for 'hold' cycles,
  // release and wait out the release debounce. Long holds are accepted by
  // the model; holds shorter than the debounce window are not.
  task automatic applyStimulus(input int mask, input int hold,
                               input logic [WIDTH-1:0] value);
    @(negedge clk);
    sw = value;
    repeat (3) @(negedge clk);
    driveButtons(mask);
    repeat (hold) @(negedge clk);
    driveButtons(0);
    repeat (DEB + 6) @(negedge clk);
    if (hold >= DEB + 2) begin
      modelOp(mask, 32'(value));
    end
  endtask

  int lat;
  logic [WIDTH-1:0] old_disp;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    sw          = 16'h1234;
    driveButtons(0);
    modelReset();

    // Reset state, then the operand passes straight through to the display.
    repeat (3) @(negedge clk);
    checkOutput("rst.disp", 32'(disp_value), 32'h0);
    checkOutput("rst.sel", 32'(reg_sel), 32'h0);
    checkOutput("rst.carry", 32'(carry), 32'h0);
    checkOutput("rst.view", 32'(view_reg), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkAll("t1");
    checkOutput("t1.passthru", 32'(disp_value), 32'h1234);

    // Store and view, then a short add glitch that must be ignored.
    applyStimulus(M_STORE, 10, 16'h00FF);
    applyStimulus(M_VIEW, 10, 16'h00FF);
    checkAll("t2");
    checkOutput("t2.reg0", 32'(disp_value), 32'h00FF);
    applyStimulus(M_ADD, 3, 16'h00FF);
    checkAll("t2.glitch");

    // Add with carry out, then store clears the carry.
    applyStimulus(M_STORE, 10, 16'hFFF0);
    applyStimulus(M_ADD, 10, 16'h0020);
    checkAll("t3.add");
    checkOutput("t3.sum", 32'(disp_value), 32'h0010);
    checkOutput("t3.c", 32'(carry), 32'h1);
    applyStimulus(M_STORE, 10, 16'h0001);
    checkOutput("t3.c0", 32'(carry), 32'h0);

    // Subtract with and without borrow.
    applyStimulus(M_STORE, 10, 16'h0005);
    applyStimulus(M_SUB, 10, 16'h0007);
    checkOutput("t4.diff", 32'(disp_value), 32'hFFFE);
    checkOutput("t4.b", 32'(carry), 32'h1);
    applyStimulus(M_SUB, 10, 16'h0002);
    checkOutput("t4.diff2", 32'(disp_value), 32'hFFFC);
    checkOutput("t4.b0", 32'(carry), 32'h0);

    // Select wraps through all registers.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(M_SEL, 10, 16'h0000);
      checkOutput("t5.sel", 32'(reg_sel), 32'(i % NUM_REGS));
    end
    checkAll("t5");
    checkOutput("t5.reg1", 32'(disp_value), 32'h0);

    // Coincident store and add: store wins, single write.
    applyStimulus(M_STORE, 10, 16'h0010);
    applyStimulus(M_STORE | M_ADD, 10, 16'h0003);
    checkAll("t6.prio");
    checkOutput("t6.reg1", 32'(disp_value), 32'h0003);

    // Press-to-display latency: 2 sync + DEB + 1 pulse + 1 display.
    @(negedge clk);
    sw = 16'h0005;
    repeat (3) @(negedge clk);
    old_disp = disp_value;
    btn_add  = 1'b1;
    lat      = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (disp_value !== old_disp) lat = k;
    end
    btn_add = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    modelOp(M_ADD, 32'h5);
    checkOutput("lat", 32'(lat), 32'(DEB + 4));
    checkAll("lat");

    // Reset during a held press: nothing is written.
    @(negedge clk);
    sw = 16'hABCD;
    repeat (3) @(negedge clk);
    btn_store = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rstmid.disp", 32'(disp_value), 32'h0);
    checkOutput("rstmid.sel", 32'(reg_sel), 32'h0);
    checkOutput("rstmid.carry", 32'(carry), 32'h0);
    checkOutput("rstmid.view", 32'(view_reg), 32'h0);
    btn_store = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    modelReset();
    repeat (DEB + 6) @(negedge clk);
    checkAll("rstmid");
    applyStimulus(M_VIEW, 10, 16'hABCD);
    checkAll("rstmid.view");
    checkOutput("rstmid.reg0", 32'(disp_value), 32'h0);

    // A button held through reset release fires exactly once.
    @(negedge clk);
    rst       = 1'b1;
    sw        = 16'h5A5A;
    btn_store = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    modelReset();
    repeat (DEB + 8) @(negedge clk);
    btn_store = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    modelOp(M_STORE, 32'h5A5A);
    applyStimulus(M_VIEW, 10, 16'h0000);
    checkAll("held");

    // Randomised press sequence against the model.
    for (int n = 0; n < 60; n++) begin
      int r;
      int mask;
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1:    mask = M_STORE;
        2, 3:    mask = M_ADD;
        4, 5:    mask = M_SUB;
        6:       mask = M_SEL;
        7:       mask = M_VIEW;
        8:       mask = M_STORE | M_ADD;
        default: mask = M_ADD | M_SUB | M_VIEW;
      endcase
      applyStimulus(mask, 10, WIDTH'($urandom));
      checkAll("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/calc_accumulator.md
Name: calc_accumulator

Overview:
- Parametrised successor of the board-level switch/button calculator: WIDTH-bit operand from switches, NUM_REGS stored accumulators, debounced buttons, add/subtract into the selected register, carry/borrow flag.
- Replaces raw-button clocking with synchronised, debounced single-cycle strobes. All state runs in the single system clock domain.
- Output value feeds the existing nibble-to-seven-segment and display mux path.

Parameters:
- WIDTH, 16, operand/register width in bits (>=4, multiple of 4 for display).
- NUM_REGS, 4, number of accumulator registers (power of two, >=2).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level is accepted (>=1). This is 10 ms at 100 MHz.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- btn_store  in  1  raw button: reg[sel] <= sw.
- btn_add  in  1  raw button: reg[sel] <= reg[sel] + sw.
- btn_sub  in  1  raw button: reg[sel] <= reg[sel] - sw.
- btn_sel  in  1  raw button: advance register select.
- btn_view  in  1  raw button: toggle display source.
- sw  in  WIDTH  operand, asynchronous to clk.
- disp_value  out  WIDTH  value to display, registered.
- reg_sel  out  $clog2(NUM_REGS)  currently selected register index.
- carry  out  1  carry from the last add, or borrow from the last sub, on the selected register.
- view_reg  out  1  0 = display shows sw, 1 = display shows reg[sel].

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - all regs 0, reg_sel 0, carry flags 0, view_reg 0, disp_value 0.
  - debounced levels 0, debounce counters 0, synchroniser flops 0.
- Input path:
  - Each button passes through a 2-flop synchroniser.
  - sw passes through a 2-flop synchroniser (sw_s); no debounce on sw.
- Debounce, per button:
  - The counter increments while the synchronised level differs from the debounced level.
  - The counter clears to 0 on any cycle they match.
  - When the counter is at DEBOUNCE_CYCLES-1 and the level still differs, the debounced level flips on that edge and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are never accepted.
- Strobe: a debounced 0->1 transition produces exactly one 1-cycle pulse, on the cycle after the flip. Release (1->0) produces nothing.
- A button held high through reset release fires once, after DEBOUNCE_CYCLES stable cycles.
- Operations take effect on the clk edge at the end of the pulse cycle. Priority when pulses coincide: store > add > sub > sel; only the winner executes. view is independent and always honoured.
  - store: reg[sel] <= sw_s; carry[sel] <= 0.
  - add: {carry[sel], reg[sel]} <= reg[sel] + sw_s, as a (WIDTH+1)-bit sum. Wraps modulo 2^WIDTH; carry = bit WIDTH.
  - sub: reg[sel] <= reg[sel] - sw_s modulo 2^WIDTH; carry[sel] <= 1 iff sw_s > reg[sel] (borrow).
  - sel: reg_sel <= reg_sel + 1; wraps from NUM_REGS-1 to 0. Register contents are unchanged.
  - view: view_reg <= ~view_reg.
- Outputs:
  - carry always reflects carry[reg_sel] and is combinational from registered state.
  - disp_value <= view_reg ? reg[reg_sel] : sw_s, updated every cycle. It lags by 1 cycle after any register, select or view change.
- Latency, raw press to register update: 2 (sync) + DEBOUNCE_CYCLES (flip) + 1 (pulse) cycles. disp_value follows 1 cycle later.
- Reset mid-debounce or mid-pulse: the operation is discarded and no partial write occurs.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=16, NUM_REGS=4):
1. Reset, sw=16'h1234, no buttons -> disp_value=16'h1234 within 3 cycles; reg_sel=0, carry=0, view_reg=0.
2. sw=16'h00FF, press store (hold 10 cycles), press view -> reg0=16'h00FF; disp_value=16'h00FF. A 3-cycle btn_add glitch produces no change.
3. reg0=16'hFFF0, sw=16'h0020, add -> reg0=16'h0010, carry=1. Then sw=16'h0001, store -> carry=0.
4. reg0=16'h0005, sw=16'h0007, sub -> reg0=16'hFFFE, carry=1. Then sw=16'h0002, sub -> reg0=16'hFFFC, carry=0.
5. Press sel 5 times -> reg_sel sequence 1,2,3,0,1. reg0 is unchanged; with view_reg=1, disp_value shows reg1 (0).
6. store and add debounced on the same cycle, sw=16'h0003, reg1=16'h0010 -> reg1=16'h0003 (store wins), exactly one write. Assert rst during a held press -> all outputs 0 and no write.
